// File: rtl/pipe_skid_stage_pkg.sv
// pipe_skid_stage_pkg: pipeline stage state encoding and per-stage payload structs
package pipe_skid_stage_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
`ifdef RISCV_FORMAL
        logic [31:0] rvfi_insn;
`endif
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
`ifdef RISCV_FORMAL
        logic [31:0] rvfi_insn;
        logic [31:0] rvfi_pc_rdata;
`endif
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
`ifdef RISCV_FORMAL
        logic [31:0] rvfi_insn;
        logic [31:0] rvfi_pc_rdata;
`endif
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_we;
`ifdef RISCV_FORMAL
        logic [31:0] rvfi_insn;
        logic [31:0] rvfi_pc_rdata;
`endif
    } mem_wb_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with optional 2-entry skid buffer
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter bit          SKID_EN        = 1'b1,
    parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] out_q, out_d, skid_q;
    logic              in_fire, out_fire;

    assign out_valid_o = state_q != PS_EMPTY;
    assign out_data_o  = out_q;
    assign occupancy_o = state_q;
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    // Next state and output register: flush beats handshakes, the skid drains into the output first
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        if (flush_i) begin
            state_d = PS_EMPTY;
            out_d   = CLEAR_ON_FLUSH ? '0 : out_q;
        end else if (state_q == PS_FULL) begin
            state_d = out_fire ? PS_BUSY : PS_FULL;
            out_d   = out_fire ? skid_q : out_q;
        end else if (in_fire) begin
            state_d = (SKID_EN && state_q == PS_BUSY && !out_fire) ? PS_FULL : PS_BUSY;
            out_d   = (SKID_EN && state_q == PS_BUSY && !out_fire) ? out_q : in_data_i;
        end else if (out_fire) begin
            state_d = PS_EMPTY;
        end
    end

    // State and output payload registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PS_EMPTY;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    if (SKID_EN) begin : g_skid
        // Ready is a pure state decode so upstream sees no path from out_ready_i
        assign in_ready_o = state_q != PS_FULL;
        // Skid entry catches the word accepted while the output is stalled
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
                skid_q <= '0;
            else if (flush_i)
                skid_q <= CLEAR_ON_FLUSH ? '0 : skid_q;
            else if (state_q == PS_BUSY && in_fire && !out_fire)
                skid_q <= in_data_i;
        end
    end else begin : g_noskid
        assign in_ready_o = !out_valid_o | out_ready_i;
        assign skid_q     = '0;
    end

    a_occ_range: assert property (@(posedge clk_i) disable iff (!rst_ni) occupancy_o <= 2'd2);
    a_no_fire_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(in_fire && state_q == PS_FULL));
    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_o && !out_ready_i && !flush_i |=> out_valid_o && $stable(out_data_o));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: queue-model random and directed checks of both skid and no-skid variants
module tb_pipe_skid_stage;

    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         flush_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] in_data_i = '0;

    logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [W-1:0] a_out_data, b_out_data;
    logic [1:0]   a_occ, b_occ;

    int total = 0;
    int passed = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] ra = '0;
    logic [W-1:0] rb = '0;

    always #5 clk_i = ~clk_i;

    pipe_skid_stage #(.DATA_W(W), .SKID_EN(1'b1), .CLEAR_ON_FLUSH(1'b1)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(a_in_ready), .in_data_i(in_data_i),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready_i), .out_data_o(a_out_data),
        .occupancy_o(a_occ)
    );

    pipe_skid_stage #(.DATA_W(W), .SKID_EN(1'b0), .CLEAR_ON_FLUSH(1'b0)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(b_in_ready), .in_data_i(in_data_i),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready_i), .out_data_o(b_out_data),
        .occupancy_o(b_occ)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit rdy_a();
        return qa.size() < 2;
    endfunction

    function automatic bit rdy_b();
        return qb.size() == 0 || out_ready_i;
    endfunction

    task automatic compare();
        chk("a_valid", 32'(a_out_valid), 32'(qa.size() > 0));
        chk("a_data",  32'(a_out_data),  32'(ra));
        chk("a_occ",   32'(a_occ),       32'(qa.size()));
        chk("a_ready", 32'(a_in_ready),  32'(rdy_a()));
        chk("b_valid", 32'(b_out_valid), 32'(qb.size() > 0));
        chk("b_data",  32'(b_out_data),  32'(rb));
        chk("b_occ",   32'(b_occ),       32'(qb.size()));
        chk("b_ready", 32'(b_in_ready),  32'(rdy_b()));
    endtask

    task automatic model_edge();
        bit fa, oa, fb, ob;
        fa = in_valid_i && rdy_a();
        oa = out_ready_i && qa.size() > 0;
        fb = in_valid_i && rdy_b();
        ob = out_ready_i && qb.size() > 0;
        if (flush_i) begin
            qa.delete();
            qb.delete();
            ra = '0;
        end else begin
            if (oa) void'(qa.pop_front());
            if (fa) qa.push_back(in_data_i);
            if (qa.size() > 0) ra = qa[0];
            if (ob) void'(qb.pop_front());
            if (fb) qb.push_back(in_data_i);
            if (qb.size() > 0) rb = qb[0];
        end
    endtask

    task automatic step(input bit fl, input bit iv, input logic [W-1:0] d, input bit ordy);
        @(negedge clk_i);
        flush_i = fl;
        in_valid_i = iv;
        in_data_i = d;
        out_ready_i = ordy;
        #1 compare();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(a_out_valid), 32'd0);
        chk("rst_data",  32'(a_out_data),  32'd0);
        chk("rst_occ",   32'(a_occ),       32'd0);
        chk("rst_ready", 32'(a_in_ready),  32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        step(0, 1, 16'h11, 1);
        chk("s1_d11", 32'(a_out_data), 32'h11);
        chk("s1_occ", 32'(a_occ), 32'd1);
        step(0, 1, 16'h22, 1);
        chk("s1_d22", 32'(a_out_data), 32'h22);
        step(0, 1, 16'h33, 1);
        chk("s1_d33", 32'(a_out_data), 32'h33);
        chk("s1_v", 32'(a_out_valid), 32'd1);
        step(0, 0, 16'h0, 1);
        chk("s1_bubble", 32'(a_out_valid), 32'd0);

        step(0, 1, 16'hA, 0);
        step(0, 1, 16'hB, 0);
        chk("s2_occ2", 32'(a_occ), 32'd2);
        chk("s2_rdy0", 32'(a_in_ready), 32'd0);
        chk("s2_dA", 32'(a_out_data), 32'hA);
        for (int i = 0; i < 10; i++) step(0, i[0], 16'hDEAD, 0);
        chk("s3_dA", 32'(a_out_data), 32'hA);
        chk("s3_occ2", 32'(a_occ), 32'd2);
        step(0, 0, 16'h0, 1);
        chk("s2_dB", 32'(a_out_data), 32'hB);
        chk("s2_rdy1", 32'(a_in_ready), 32'd1);
        step(0, 0, 16'h0, 1);
        chk("s2_empty", 32'(a_occ), 32'd0);

        step(0, 1, 16'h1, 0);
        step(0, 1, 16'h2, 0);
        step(1, 1, 16'h55, 0);
        chk("s4_v0", 32'(a_out_valid), 32'd0);
        chk("s4_d0", 32'(a_out_data), 32'd0);
        chk("s4_occ0", 32'(a_occ), 32'd0);
        step(0, 1, 16'h3, 0);
        step(1, 1, 16'h55, 1);
        chk("s4b_v0", 32'(a_out_valid), 32'd0);
        chk("s4b_d0", 32'(a_out_data), 32'd0);
        step(0, 0, 16'h0, 1);
        chk("s4_no55", 32'(a_out_valid), 32'd0);

        step(0, 1, 16'h61, 1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        #1 chk("s5_rdy_lo", 32'(b_in_ready), 32'd0);
        out_ready_i = 1'b1;
        #1 chk("s5_rdy_hi", 32'(b_in_ready), 32'd1);
        out_ready_i = 1'b0;
        step(0, 1, 16'h62, 0);
        chk("s5_hold61", 32'(b_out_data), 32'h61);
        step(0, 1, 16'h63, 1);
        chk("s5_d63", 32'(b_out_data), 32'h63);
        chk("s5_occ1", 32'(b_occ), 32'd1);

        step(1, 0, 16'h0, 0);
        step(0, 1, 16'h71, 0);
        step(0, 1, 16'h72, 0);
        chk("s6_full", 32'(a_occ), 32'd2);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("s6_v0", 32'(a_out_valid), 32'd0);
        chk("s6_occ0", 32'(a_occ), 32'd0);
        chk("s6_rdy1", 32'(a_in_ready), 32'd1);
        chk("s6_b_v0", 32'(b_out_valid), 32'd0);
        qa.delete();
        qb.delete();
        ra = '0;
        rb = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 15) == 0, 1'($urandom), W'($urandom), $urandom_range(0, 3) != 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
